mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage, the receiving end of the EXU->MEM valid/allow_in handshake.
//  Latches the EXU payload: pc, inst, alu_result and {res_from_mem, gr_we, dest}.
//  Picks the data-SRAM read data or alu_result as final_result and sends it to WB.
//  Also drives the MEM->IDU bypass/hazard signals. Sits between EXU and WBU.
// PARAMETERS
//  none (field widths fixed by ISA: 32b data/pc/inst, 5b dest)
// PORTS
//  clk                     in   1   clock; all state updates on posedge
//  reset                   in   1   synchronous, active-high
//  EXU_to_MEM_valid        in   1   EXU holds a valid instruction
//  MEM_allow_in            out  1   MEM can accept this cycle
//  WB_allow_in             in   1   WB can accept this cycle
//  MEM_ready_go            out  1   MEM result complete
//  MEM_to_WB_valid         out  1   valid instruction offered to WB
//  EXU_pc_to_MEM           in   32  pc of incoming instruction
//  EXU_inst_to_MEM         in   32  instruction word
//  EXU_alu_result_to_MEM   in   32  ALU result / memory address
//  EXU_signals_pass_to_MEM in   7   {res_from_mem, gr_we, dest[4:0]}
//  data_sram_rdata         in   32  sync-read data for address EXU issued last cycle
//  MEM_pc_to_WB            out  32  latched pc
//  MEM_inst_to_WB          out  32  latched inst
//  MEM_final_result_to_WB  out  32  res_from_mem ? load data : alu_result
//  MEM_signals_pass_to_WB  out  6   {gr_we, dest[4:0]}
//  MEM_to_IDU_gr_we        out  1   latched gr_we
//  MEM_to_IDU_dest         out  5   latched dest
//  MEM_to_IDU_valid        out  1   = MEM_valid
//  MEM_to_IDU_forward      out  32  = MEM_final_result_to_WB
// BEHAVIOUR
//  - accept = EXU_to_MEM_valid & MEM_allow_in. Latch pc/inst/alu_result/signals only on accept;
//    hold them otherwise, including during stalls.
//  - MEM_valid: reset -> 0; when MEM_allow_in, MEM_valid <= EXU_to_MEM_valid; else hold.
//  - MEM_ready_go = 1. MEM_to_WB_valid = MEM_valid & MEM_ready_go.
//  - MEM_allow_in = !MEM_valid | (MEM_ready_go & WB_allow_in). It is 1 in the cycle after reset.
//  - Latency: 1 cycle. An instruction accepted at edge N is offered to WB during cycle N..N+1.
//  - Load-data hold: data_sram_rdata is only valid in the first cycle after accept (first_cyc=1).
//    first_cyc: reset 0; set on accept; cleared on any edge without accept.
//    rdata_buf <= data_sram_rdata when first_cyc & MEM_valid.
//    load_data = first_cyc ? data_sram_rdata : rdata_buf.
//    The SRAM is always enabled and will show the next address's data during a WB stall.
//    final_result must still stay stable across any number of stall cycles.
//  - Back-to-back accept (new accept while MEM_valid & WB_allow_in): first_cyc stays 1.
//    Data goes to the new instruction.
//  - gr_we is passed unqualified. IDU combines it with MEM_to_IDU_valid. Store instructions
//    arrive with gr_we=0 and res_from_mem=0.
//  - Reset values: all latched regs 0, rdata_buf 0, MEM_valid 0, first_cyc 0.
//    Therefore every data output is 0 and MEM_to_WB_valid = MEM_to_IDU_valid = 0.
//  - Reset asserted mid-stall discards the held instruction. No WB handshake occurs for it.
// STRUCTURE
//  - Shared header mycpu_defs.vh: field widths for the EX->MEM bus (7) and MEM->WB bus (6),
//    plus bit positions of res_from_mem / gr_we / dest. EXU, MEM and WB all include it.
//  - Single flat module. No sub-module needed; the load-data hold is ~10 lines inline.
// TESTING
//  - Reset 3 cycles -> MEM_to_WB_valid=0, MEM_allow_in=1, all data outputs 0.
//  - ALU op: pc=0x1c000000, alu=0x1234, signals=7'b0100101, WB_allow_in=1
//    -> next cycle final_result=0x1234, signals_pass=6'b100101, valid=1 for exactly 1 cycle.
//  - Load: res_from_mem=1, rdata=0xdeadbeef in first cycle -> final_result=0xdeadbeef,
//    MEM_to_IDU_forward=0xdeadbeef, dest matches.
//  - Load + stall: WB_allow_in=0 for 4 cycles while rdata changes to 0x0 -> final_result stays
//    0xdeadbeef, MEM_allow_in=0, all payload held. Exactly one handshake when WB_allow_in=1.
//  - Back-to-back: 3 consecutive valid instructions (alu 1,2,3), WB always ready
//    -> WB sees 1,2,3 on consecutive cycles, no bubble, no duplicate.
//  - Reset mid-stall with a valid load held -> next cycle MEM_valid=0, final_result=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared field widths and payload layout for the EXU->MEM and MEM->WB buses.
package mem_stage_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned DEST_W       = 5;
    localparam int unsigned EX_MEM_BUS_W = DEST_W + 2;
    localparam int unsigned MEM_WB_BUS_W = DEST_W + 1;

    typedef struct packed {
        logic              res_from_mem;
        logic              gr_we;
        logic [DEST_W-1:0] dest;
    } ex_sig_t;

    function automatic logic [XLEN-1:0] select_result(
        input logic            res_from_mem,
        input logic [XLEN-1:0] load_data,
        input logic [XLEN-1:0] alu_result
    );
        return res_from_mem ? load_data : alu_result;
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EXU payload, selects load data or ALU
// result for WB, and drives the MEM->IDU bypass signals.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    EXU_to_MEM_valid,
    output logic                    MEM_allow_in,
    input  logic                    WB_allow_in,
    output logic                    MEM_ready_go,
    output logic                    MEM_to_WB_valid,
    input  logic [XLEN-1:0]         EXU_pc_to_MEM,
    input  logic [XLEN-1:0]         EXU_inst_to_MEM,
    input  logic [XLEN-1:0]         EXU_alu_result_to_MEM,
    input  logic [EX_MEM_BUS_W-1:0] EXU_signals_pass_to_MEM,
    input  logic [XLEN-1:0]         data_sram_rdata,
    output logic [XLEN-1:0]         MEM_pc_to_WB,
    output logic [XLEN-1:0]         MEM_inst_to_WB,
    output logic [XLEN-1:0]         MEM_final_result_to_WB,
    output logic [MEM_WB_BUS_W-1:0] MEM_signals_pass_to_WB,
    output logic                    MEM_to_IDU_gr_we,
    output logic [DEST_W-1:0]       MEM_to_IDU_dest,
    output logic                    MEM_to_IDU_valid,
    output logic [XLEN-1:0]         MEM_to_IDU_forward
);

    logic            mem_valid_q, mem_valid_d;
    logic            first_cyc_q, first_cyc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    ex_sig_t         sig_q, sig_d;
    logic [XLEN-1:0] rdata_buf_q, rdata_buf_d;

    logic            accept;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] final_result;

    always_comb begin
        MEM_ready_go = 1'b1;
        MEM_allow_in = !mem_valid_q | (MEM_ready_go & WB_allow_in);
        accept       = EXU_to_MEM_valid & MEM_allow_in;

        mem_valid_d  = mem_valid_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        alu_result_d = alu_result_q;
        sig_d        = sig_q;
        rdata_buf_d  = rdata_buf_q;

        if (MEM_allow_in) begin
            mem_valid_d = EXU_to_MEM_valid;
        end
        if (accept) begin
            pc_d         = EXU_pc_to_MEM;
            inst_d       = EXU_inst_to_MEM;
            alu_result_d = EXU_alu_result_to_MEM;
            sig_d        = ex_sig_t'(EXU_signals_pass_to_MEM);
        end

        // SRAM data is only valid in the first cycle; capture it so a WB stall
        // cannot let the next address's data leak into the held result.
        first_cyc_d = accept;
        if (first_cyc_q & mem_valid_q) begin
            rdata_buf_d = data_sram_rdata;
        end

        load_data    = first_cyc_q ? data_sram_rdata : rdata_buf_q;
        final_result = select_result(sig_q.res_from_mem, load_data, alu_result_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            first_cyc_q  <= 1'b0;
            pc_q         <= '0;
            inst_q       <= '0;
            alu_result_q <= '0;
            sig_q        <= '0;
            rdata_buf_q  <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            first_cyc_q  <= first_cyc_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            alu_result_q <= alu_result_d;
            sig_q        <= sig_d;
            rdata_buf_q  <= rdata_buf_d;
        end
    end

    assign MEM_to_WB_valid        = mem_valid_q & MEM_ready_go;
    assign MEM_pc_to_WB           = pc_q;
    assign MEM_inst_to_WB         = inst_q;
    assign MEM_final_result_to_WB = final_result;
    assign MEM_signals_pass_to_WB = {sig_q.gr_we, sig_q.dest};
    assign MEM_to_IDU_gr_we       = sig_q.gr_we;
    assign MEM_to_IDU_dest        = sig_q.dest;
    assign MEM_to_IDU_valid       = mem_valid_q;
    assign MEM_to_IDU_forward     = final_result;

endmodule
